// File: rtl/ltc2308_spi_responder_pkg.sv
// Shared definitions for the LTC2308 responder: config word layout,
// the reset config, FSM state encoding and the config-to-channel map.
package ltc2308_spi_responder_pkg;

    localparam int unsigned CFG_W   = 6;
    localparam int unsigned CFG_SD  = 5;
    localparam int unsigned CFG_OS  = 4;
    localparam int unsigned CFG_S1  = 3;
    localparam int unsigned CFG_S0  = 2;
    localparam int unsigned CFG_UNI = 1;
    localparam int unsigned CFG_SLP = 0;

    // Single-ended, CH0, unipolar, no sleep.
    localparam logic [CFG_W-1:0] CFG_RESET = 6'b100010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    // Datasheet channel map: index = {S1, S0, O/S}.
    function automatic logic [2:0] cfg2ch(input logic [CFG_W-1:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction

endpackage

// File: rtl/ltc2308_spi_responder_if.sv
// Serial link between the LTC2308 controller (master) and the ADC (slave).
interface ltc2308_spi_responder_if;
    logic ADC_CONVST;
    logic ADC_SCK;
    logic ADC_SDI;
    logic ADC_SDO;

    modport master (
        output ADC_CONVST,
        output ADC_SCK,
        output ADC_SDI,
        input  ADC_SDO
    );

    modport slave (
        input  ADC_CONVST,
        input  ADC_SCK,
        input  ADC_SDI,
        output ADC_SDO
    );
endinterface

// File: rtl/ltc2308_spi_responder_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall detect
// on the synchronized level.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic adc_clk,
    input  logic adc_reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the input through the synchronizer and keep one sample of history.
    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ltc2308_spi_responder.sv
// LTC2308 serial ADC responder: SPI slave returning per-channel sample
// values loaded from a local port, with the pipelined config frame.
module ltc2308_spi_responder
    import ltc2308_spi_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CONV_CYCLES = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       adc_clk,
    input  logic                       adc_reset,
    ltc2308_spi_responder_if.slave     spi,
    input  logic                       load_valid,
    input  logic [$clog2(NUM_CH)-1:0]  load_ch,
    input  logic [DATA_W-1:0]          load_data,
    output logic                       frame_done,
    output logic [CFG_W-1:0]           cfg_last,
    output logic                       conv_busy,
    output logic                       err_frame
);

    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int unsigned BC_W  = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0]  CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
    localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0]   BIT_END   = BC_W'(DATA_W);
    localparam logic [2:0]        SDI_FULL  = 3'(CFG_W);
    localparam logic [DATA_W-1:0] SIGN_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

    logic conv_level, conv_rise, conv_fall;
    logic sck_level,  sck_rise,  sck_fall;
    logic sdi_level,  sdi_rise,  sdi_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_convst (
        .adc_clk   (adc_clk),
        .adc_reset (adc_reset),
        .d         (spi.ADC_CONVST),
        .level     (conv_level),
        .rise      (conv_rise),
        .fall      (conv_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .adc_clk   (adc_clk),
        .adc_reset (adc_reset),
        .d         (spi.ADC_SCK),
        .level     (sck_level),
        .rise      (sck_rise),
        .fall      (sck_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .adc_clk   (adc_clk),
        .adc_reset (adc_reset),
        .d         (spi.ADC_SDI),
        .level     (sdi_level),
        .rise      (sdi_rise),
        .fall      (sdi_fall)
    );

    // S/D and SLP are accepted but have no effect on the returned data.
    logic unused_sig;
    assign unused_sig = ^{conv_level, conv_fall, sck_level, sdi_rise, sdi_fall,
                          cfg_last[CFG_SD], cfg_last[CFG_SLP]};

    logic [DATA_W-1:0] chan_reg [NUM_CH];

    state_t            state;
    logic [CFG_W-1:0]  pending_cfg;
    logic [CNT_W-1:0]  conv_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [BC_W-1:0]   bit_cnt;
    logic [2:0]        sdi_cnt;
    logic [CFG_W-1:0]  sdi_sr;
    logic              sdo_q;

    logic              sck_rise_act;
    logic              sck_fall_act;
    logic              last_fall;
    logic [CFG_W-1:0]  sdi_sr_nxt;
    logic [2:0]        sdi_cnt_nxt;
    logic [BC_W-1:0]   bit_cnt_nxt;
    logic              cfg_full;
    logic [DATA_W-1:0] cap_word;

    assign spi.ADC_SDO = sdo_q;

    // Channel register file written from the local load port.
    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                chan_reg[i] <= '0;
            end
        end else if (load_valid) begin
            chan_reg[load_ch] <= load_data;
        end
    end

    // Next-value views of the frame counters so a CONVST rise coinciding
    // with the final SCK edge sees that edge as already taken.
    always_comb begin
        sck_fall_act = sck_fall && (bit_cnt < BIT_END);
        last_fall    = sck_fall_act && (bit_cnt == BIT_LAST);
        sck_rise_act = sck_rise && (sdi_cnt < SDI_FULL);
        sdi_sr_nxt   = sck_rise_act ? {sdi_sr[CFG_W-2:0], sdi_level} : sdi_sr;
        sdi_cnt_nxt  = sck_rise_act ? sdi_cnt + 3'd1 : sdi_cnt;
        bit_cnt_nxt  = sck_fall_act ? bit_cnt + BC_W'(1) : bit_cnt;
        cfg_full     = (sdi_cnt_nxt == SDI_FULL);
        cap_word     = chan_reg[cfg2ch(cfg_last)] ^
                       (cfg_last[CFG_UNI] ? '0 : SIGN_FLIP);
    end

    // Conversion/shift FSM with registered SDO and status outputs.
    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            state       <= IDLE;
            sdo_q       <= 1'b0;
            frame_done  <= 1'b0;
            conv_busy   <= 1'b0;
            err_frame   <= 1'b0;
            cfg_last    <= CFG_RESET;
            pending_cfg <= CFG_RESET;
            conv_cnt    <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            sdi_cnt     <= '0;
            sdi_sr      <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    sdo_q <= 1'b0;
                    if (conv_rise) begin
                        cfg_last  <= pending_cfg;
                        conv_cnt  <= CONV_LOAD;
                        conv_busy <= 1'b1;
                        state     <= CONVERT;
                    end
                end

                CONVERT: begin
                    sdo_q <= 1'b0;
                    if (conv_rise) begin
                        err_frame <= 1'b1;
                    end
                    if (conv_cnt == '0) begin
                        shift_reg <= cap_word;
                        sdo_q     <= cap_word[DATA_W-1];
                        bit_cnt   <= '0;
                        sdi_cnt   <= '0;
                        conv_busy <= 1'b0;
                        state     <= SHIFT;
                    end else begin
                        conv_cnt <= conv_cnt - CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (sck_rise_act) begin
                        sdi_sr  <= sdi_sr_nxt;
                        sdi_cnt <= sdi_cnt_nxt;
                    end
                    if (sck_fall_act) begin
                        bit_cnt   <= bit_cnt_nxt;
                        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                        if (last_fall) begin
                            sdo_q      <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            sdo_q <= shift_reg[DATA_W-2];
                        end
                    end
                    if (conv_rise) begin
                        if (cfg_full) begin
                            pending_cfg <= sdi_sr_nxt;
                            cfg_last    <= sdi_sr_nxt;
                        end else begin
                            cfg_last    <= pending_cfg;
                        end
                        if (!cfg_full || (bit_cnt_nxt < BIT_END)) begin
                            err_frame <= 1'b1;
                        end
                        sdo_q     <= 1'b0;
                        conv_cnt  <= CONV_LOAD;
                        conv_busy <= 1'b1;
                        state     <= CONVERT;
                    end
                end

                default: begin
                    sdo_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2308_spi_responder.sv
// Directed bench for the LTC2308 responder: drives CONVST/SCK/SDI as the
// controller would and checks returned words, timing and status flags.
module tb_ltc2308_spi_responder;

    localparam int H = 4;   // SCK half period in adc_clk cycles

    logic        clk;
    logic        adc_reset;
    logic        load_valid;
    logic [2:0]  load_ch;
    logic [11:0] load_data;
    logic        frame_done;
    logic [5:0]  cfg_last;
    logic        conv_busy;
    logic        err_frame;

    int checks;
    int errors;
    int fd_high;

    ltc2308_spi_responder_if spi_if ();

    ltc2308_spi_responder #(
        .DATA_W      (12),
        .NUM_CH      (8),
        .CONV_CYCLES (64),
        .SYNC_STAGES (2)
    ) dut (
        .adc_clk    (clk),
        .adc_reset  (adc_reset),
        .spi        (spi_if),
        .load_valid (load_valid),
        .load_ch    (load_ch),
        .load_data  (load_data),
        .frame_done (frame_done),
        .cfg_last   (cfg_last),
        .conv_busy  (conv_busy),
        .err_frame  (err_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count adc_clk cycles with frame_done high.
    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_high++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] ch, input logic [11:0] data);
        load_valid = 1'b1;
        load_ch    = ch;
        load_data  = data;
        tick(1);
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        adc_reset = 1'b1;
        tick(3);
        adc_reset = 1'b0;
        tick(1);
    endtask

    // Pulse CONVST, check the config used and the CONVERT length; optionally
    // re-raise CONVST ten cycles into the conversion.
    task automatic start_conv(input string tag, input logic [5:0] exp_cfg, input bit inject);
        int n;
        spi_if.ADC_CONVST = 1'b1;
        tick(2);
        spi_if.ADC_CONVST = 1'b0;
        n = 0;
        while (conv_busy !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check({tag, "_busy"}, {31'd0, conv_busy}, 32'd1);
        check({tag, "_cfg_last"}, {26'd0, cfg_last}, {26'd0, exp_cfg});
        n = 0;
        while (conv_busy === 1'b1 && n < 200) begin
            if (inject && n == 10) spi_if.ADC_CONVST = 1'b1;
            if (inject && n == 12) spi_if.ADC_CONVST = 1'b0;
            tick(1);
            n++;
        end
        check({tag, "_conv_len"}, n, 32'd64);
    endtask

    // Clock nsck SCK periods, shifting cfg MSB first and sampling SDO
    // before each rising edge.
    task automatic run_frame(input string tag, input logic [5:0] cfg,
                             input logic [11:0] exp_data, input int nsck);
        logic [11:0] got;
        int          fd0;
        got = '0;
        fd0 = fd_high;
        for (int i = 0; i < nsck; i++) begin
            spi_if.ADC_SDI = (i < 6) ? cfg[5-i] : 1'b0;
            if (i < 12) got[11-i] = spi_if.ADC_SDO;
            spi_if.ADC_SCK = 1'b1;
            tick(H);
            spi_if.ADC_SCK = 1'b0;
            tick(H);
        end
        spi_if.ADC_SDI = 1'b0;
        tick(2);
        if (nsck == 12) begin
            check({tag, "_data"}, {20'd0, got}, {20'd0, exp_data});
            check({tag, "_sdo_idle"}, {31'd0, spi_if.ADC_SDO}, 32'd0);
            check({tag, "_frame_done"}, fd_high - fd0, 32'd1);
        end else begin
            check({tag, "_no_frame_done"}, fd_high - fd0, 32'd0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        fd_high    = 0;
        adc_reset  = 1'b1;
        load_valid = 1'b0;
        load_ch    = '0;
        load_data  = '0;
        spi_if.ADC_CONVST = 1'b0;
        spi_if.ADC_SCK    = 1'b0;
        spi_if.ADC_SDI    = 1'b0;
        tick(3);
        adc_reset = 1'b0;
        tick(1);

        // Reset state
        check("rst_sdo", {31'd0, spi_if.ADC_SDO}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_busy", {31'd0, conv_busy}, 32'd0);
        check("rst_err", {31'd0, err_frame}, 32'd0);
        check("rst_cfg_last", {26'd0, cfg_last}, 32'h22);

        // Basic frame, CH0
        load(3'd0, 12'hABC);
        start_conv("t1", 6'b100010, 1'b0);
        run_frame("t1", 6'b100010, 12'hABC, 12);
        check("t1_err", {31'd0, err_frame}, 32'd0);

        // Pipelined config: frame 1 selects CH1 for conversion 2
        load(3'd0, 12'h123);
        load(3'd1, 12'h456);
        start_conv("t2a", 6'b100010, 1'b0);
        run_frame("t2a", 6'b110010, 12'h123, 12);
        start_conv("t2b", 6'b110010, 1'b0);
        run_frame("t2b", 6'b100100, 12'h456, 12);

        // Bipolar on CH2 = 0 returns mid-scale flip
        load(3'd2, 12'h000);
        start_conv("t3", 6'b100100, 1'b0);
        run_frame("t3", 6'b100010, 12'h800, 12);
        check("t3_err", {31'd0, err_frame}, 32'd0);

        // CONVST rise during CONVERT: error, timing unchanged
        start_conv("t5", 6'b100010, 1'b1);
        run_frame("t5", 6'b100010, 12'h123, 12);
        check("t5_err", {31'd0, err_frame}, 32'd1);

        // Short frame keeps the pending config
        do_reset();
        check("t4_err_clear", {31'd0, err_frame}, 32'd0);
        load(3'd0, 12'h321);
        load(3'd1, 12'h654);
        start_conv("t4a", 6'b100010, 1'b0);
        run_frame("t4a", 6'b110010, 12'h000, 4);
        check("t4_err_before", {31'd0, err_frame}, 32'd0);
        start_conv("t4b", 6'b100010, 1'b0);
        check("t4_err_after", {31'd0, err_frame}, 32'd1);
        run_frame("t4b", 6'b100010, 12'h321, 12);

        // Reset in the middle of SHIFT
        do_reset();
        load(3'd0, 12'h0F0);
        load(3'd5, 12'hAAA);
        start_conv("t6a", 6'b100010, 1'b0);
        run_frame("t6a", 6'b111010, 12'h0F0, 12);
        start_conv("t6b", 6'b111010, 1'b0);
        run_frame("t6b", 6'b100010, 12'h000, 2);
        check("t6_sdo_mid", {31'd0, spi_if.ADC_SDO}, 32'd1);
        adc_reset = 1'b1;
        tick(1);
        check("t6_rst_sdo", {31'd0, spi_if.ADC_SDO}, 32'd0);
        check("t6_rst_cfg", {26'd0, cfg_last}, 32'h22);
        check("t6_rst_busy", {31'd0, conv_busy}, 32'd0);
        tick(2);
        adc_reset = 1'b0;
        tick(1);
        load(3'd0, 12'h5A5);
        start_conv("t6c", 6'b100010, 1'b0);
        run_frame("t6c", 6'b100010, 12'h5A5, 12);
        check("t6_err", {31'd0, err_frame}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
